octree_mem_arbiter: RTL
=======================

// Module: octree_mem_arbiter
// PURPOSE
//   Parametrised N-requester arbiter for the single main-memory SRAM port of the octree engine.
//   Replaces the fixed 3-way select mux: requesters (searcher, updater, future DMA/prefetch)
//   raise requests, win a locked burst grant, and drive the SRAM through it.
//   Read data returns to the issuing requester, tagged and aligned to the SRAM read latency.
// PARAMETERS
//   NUM_REQ         3    number of requesters (>=2)
//   ADDR_BUS_WIDTH  64   SRAM address width
//   DATA_BUS_WIDTH  64   SRAM data width
//   MAX_BURST       9    max beats per grant (one anchor feature = 9 beats)
//   READ_LATENCY    1    cycles from read beat to valid sram_Q (>=1)
//   ARB_MODE        0    0 = fixed priority (index 0 highest), 1 = round robin
// PORTS
//   clk           in   1                          clock
//   rst           in   1                          async reset, active-high
//   req_valid     in   NUM_REQ                    per-requester beat valid
//   req_last      in   NUM_REQ                    final beat of the burst (releases lock)
//   req_gwen      in   NUM_REQ                    0 = write, 1 = read
//   req_addr      in   NUM_REQ x ADDR_BUS_WIDTH   per-requester address
//   req_wdata     in   NUM_REQ x DATA_BUS_WIDTH   per-requester write data
//   req_ready     out  NUM_REQ                    beat accepted this cycle
//   rsp_valid     out  NUM_REQ                    read data valid for requester i
//   rsp_rdata     out  DATA_BUS_WIDTH             shared read-data bus
//   grant_id      out  $clog2(NUM_REQ)            current owner (meaningful when busy=1)
//   busy          out  1                          lock held
//   burst_err     out  1                          sticky: a burst hit MAX_BURST without last
//   sram_CEN      out  1                          chip enable, active-low
//   sram_A        out  ADDR_BUS_WIDTH             address
//   sram_D        out  DATA_BUS_WIDTH             write data
//   sram_GWEN     out  1                          0 = write, 1 = read
//   sram_Q        in   DATA_BUS_WIDTH             read data
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, grant_id=0, req_ready=0, rsp_valid=0, rsp_rdata=0, burst_err=0,
//     sram_CEN=1, sram_GWEN=1, sram_A=0, sram_D=0, RR pointer=0, read pipe flushed.
//   FSM IDLE -> GRANT
//     - In IDLE, if any req_valid is set, a winner is picked by ARB_MODE and registered into grant_id.
//     - The next cycle the FSM is in GRANT with busy=1.
//     - No beat is accepted in IDLE (1-cycle arbitration bubble).
//   GRANT
//     - req_ready[grant_id] = 1 combinationally; all other req_ready bits are 0.
//     - A beat fires when req_valid[g] && req_ready[g]. On a fire:
//       sram_CEN=0, sram_A/D/GWEN = the granted requester's fields, same cycle (pass-through).
//     - Cycles without a fire: sram_CEN=1, GWEN=1, A=0, D=0.
//     - Beat counter is cleared on grant and increments per fire.
//     - Fire with req_last, or fire with count==MAX_BURST-1: return to IDLE next cycle.
//     - If release happens without req_last (MAX_BURST reached), set burst_err (sticky until rst).
//   Round robin
//     - On each grant, the pointer moves to winner+1 (mod NUM_REQ).
//     - The search starts at the pointer. Fixed priority ignores the pointer.
//   Read return
//     - Each read fire pushes {1,grant_id} into a READ_LATENCY-deep shift pipe.
//     - At the pipe output: rsp_valid[id]=1 and rsp_rdata=sram_Q; other cycles rsp_valid=0 and rsp_rdata holds.
//     - Returns are unaffected by later grant changes: in-flight reads complete to their tag.
//   Writes produce no response.
//   Boundaries
//     - Grant-holder drops req_valid mid-burst: the lock is held and idle cycles are inserted.
//     - Simultaneous requests in IDLE: exactly one winner.
//     - NUM_REQ not a power of two: pointer wraps at NUM_REQ-1 -> 0.
//     - req_last on a non-firing cycle is ignored.
//     - rst mid-burst or with reads in flight: all state is cleared immediately and no stale rsp_valid is emitted.
// STRUCTURE
//   Package octree_mem_pkg:
//     - arb_mode_e {ARB_FIXED, ARB_RR}
//     - arb_state_e {IDLE, GRANT}
//     - localparam REQ_ID_W = $clog2(NUM_REQ) helper
//     - SRAM idle-value constants
//   Sub-module octree_rr_arbiter (req vector + pointer -> one-hot/index winner).
//   FSM, burst counter and read pipe live in the top.
// TESTING
//   1. Reset: rst=1 with all req_valid=1 -> sram_CEN=1, all req_ready=0, rsp_valid=0, busy=0.
//   2. Fixed priority: req_valid=3'b110 -> grant_id=1 after 1 cycle.
//      3-beat read burst to A=0x10..0x12, last on beat 3 -> rsp_valid[1] at fire+READ_LATENCY
//      with the model's Q; then IDLE; req 2 granted next.
//   3. Round robin: all three requesting, 1-beat bursts -> grant order 0,1,2,0; never starves 2.
//   4. Burst limit: requester 0 writes 9 beats with no req_last -> forced release after beat 9,
//      burst_err=1; beat 10 is not accepted until re-grant.
//   5. Tag integrity: READ_LATENCY=2, requester 0 reads last beat then requester 1 reads immediately
//      -> rsp_valid[0] then rsp_valid[1] with the correct data, no cross-delivery.
//   6. Reset mid-burst: assert rst with 2 reads in flight -> no rsp_valid afterwards,
//      busy=0, RR pointer=0.

Source files
------------

// File: rtl/octree_mem_pkg.sv
// Shared types and constants for the octree main-memory SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package octree_mem_pkg;

    // Arbitration policy selector
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Lock FSM: IDLE arbitrates, GRANT owns the SRAM port until release
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Requester-index width for the default three-requester build
    localparam int DEFAULT_NUM_REQ = 3;
    localparam int REQ_ID_W        = $clog2(DEFAULT_NUM_REQ);

    // Index width for an arbitrary requester count, never narrower than one bit
    function automatic int req_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // SRAM pin values driven on cycles with no accepted beat
    localparam logic SRAM_CEN_IDLE   = 1'b1;
    localparam logic SRAM_GWEN_IDLE  = 1'b1;
    localparam logic SRAM_GWEN_WRITE = 1'b0;

endpackage

// File: rtl/octree_rr_arbiter.sv
// Picks one requester, searching upward from ptr and wrapping at NUM_REQ-1.
// Latency: purely combinational.
// Backpressure: none; caller decides when the winner is taken.
module octree_rr_arbiter
    import octree_mem_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = req_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    logic found;
    int   slot;

    // First set request at or after ptr (mod NUM_REQ) wins; ptr=0 gives fixed priority
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!found && req[slot]) begin
                found          = 1'b1;
                grant_oh[slot] = 1'b1;
                grant_idx      = ID_W'(slot);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/octree_mem_arbiter.sv
// N-way locked-burst arbiter for the octree engine's single main-memory SRAM port.
// Latency: 1-cycle arbitration bubble, then beats pass straight to SRAM; read data returns READ_LATENCY cycles after its beat.
// Backpressure: only the lock owner sees req_ready; others wait, owner may stall with idle cycles while holding the lock.
module octree_mem_arbiter
    import octree_mem_pkg::*;
#(
    parameter  int NUM_REQ        = 3,
    parameter  int ADDR_BUS_WIDTH = 64,
    parameter  int DATA_BUS_WIDTH = 64,
    parameter  int MAX_BURST      = 9,
    parameter  int READ_LATENCY   = 1,
    parameter  int ARB_MODE       = 0,
    localparam int ID_W           = req_id_width(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0]                      req_last,
    input  logic [NUM_REQ-1:0]                      req_gwen,
    input  logic [NUM_REQ-1:0][ADDR_BUS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_BUS_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [DATA_BUS_WIDTH-1:0]               rsp_rdata,
    output logic [ID_W-1:0]                         grant_id,
    output logic                                    busy,
    output logic                                    burst_err,
    output logic                                    sram_CEN,
    output logic [ADDR_BUS_WIDTH-1:0]               sram_A,
    output logic [DATA_BUS_WIDTH-1:0]               sram_D,
    output logic                                    sram_GWEN,
    input  logic [DATA_BUS_WIDTH-1:0]               sram_Q
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Tag carried alongside each read beat until its data comes back
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    arb_state_e                state;
    logic [CNT_W-1:0]          beat_cnt;
    logic [NUM_REQ-1:0]        grant_oh_q;
    logic [ID_W-1:0]           rr_ptr;
    logic [ID_W-1:0]           arb_ptr;
    logic [ID_W-1:0]           next_ptr;
    logic [NUM_REQ-1:0]        win_oh;
    logic [ID_W-1:0]           win_idx;
    logic                      any_req;
    logic                      fire;
    logic                      fire_last;
    logic                      cap_hit;
    logic                      release_lock;
    rd_tag_t                   rd_push;
    rd_tag_t                   rd_out;
    rd_tag_t [READ_LATENCY-1:0] rd_pipe;
    logic [DATA_BUS_WIDTH-1:0] rdata_hold;

    // Fixed priority always searches from requester 0
    assign arb_ptr = (ARB_MODE == int'(ARB_RR)) ? rr_ptr : '0;

    octree_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (arb_ptr),
        .grant_oh  (win_oh),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    // Pointer moves just past the winner, wrapping at NUM_REQ-1 even for non-power-of-two counts
    assign next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // grant_oh_q is cleared whenever the lock is not held, so it doubles as the ready vector
    assign req_ready    = grant_oh_q;
    assign fire         = |(req_valid & req_ready);
    assign fire_last    = req_last[grant_id];
    assign cap_hit      = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign release_lock = fire & (fire_last | cap_hit);

    // Lock FSM with beat counter, round-robin pointer and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            grant_id   <= '0;
            grant_oh_q <= '0;
            beat_cnt   <= '0;
            rr_ptr     <= '0;
            burst_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= GRANT;
                        busy       <= 1'b1;
                        grant_id   <= win_idx;
                        grant_oh_q <= win_oh;
                        beat_cnt   <= '0;
                        rr_ptr     <= next_ptr;
                    end
                end
                GRANT: begin
                    if (fire) begin
                        if (release_lock) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            grant_oh_q <= '0;
                            beat_cnt   <= '0;
                            if (!fire_last) begin
                                burst_err <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner's beat goes straight to the SRAM pins; pins park at idle values otherwise
    always_comb begin
        sram_CEN  = SRAM_CEN_IDLE;
        sram_GWEN = SRAM_GWEN_IDLE;
        sram_A    = '0;
        sram_D    = '0;
        if (fire) begin
            sram_CEN  = 1'b0;
            sram_GWEN = req_gwen[grant_id];
            sram_A    = req_addr[grant_id];
            sram_D    = req_wdata[grant_id];
        end
    end

    assign rd_push = '{vld: fire & (req_gwen[grant_id] != SRAM_GWEN_WRITE), id: grant_id};
    assign rd_out  = rd_pipe[READ_LATENCY-1];

    // Tag shift pipe matched to SRAM read latency; later grant changes cannot retag in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            rd_pipe[0] <= rd_push;
        end
    end

    // Last returned word is held so rsp_rdata stays stable between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold <= '0;
        end else if (rd_out.vld) begin
            rdata_hold <= sram_Q;
        end
    end

    // Steer the returning word to the requester named in its tag
    always_comb begin
        rsp_valid = '0;
        if (rd_out.vld) begin
            rsp_valid[rd_out.id] = 1'b1;
        end
    end

    assign rsp_rdata = rd_out.vld ? sram_Q : rdata_hold;

endmodule
